// File: rtl/juego_control.sv
// Tic-tac-toe match sequencer: owns the 3x3 board, the player turn and the
// saturating match tallies. Win detection is external; this block only drives
// the board out and samples the checker's verdict one cycle after each move.
module juego_control #(
  parameter int unsigned SCORE_W   = 4,
  parameter bit          ALT_START = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               move_valid,
  input  logic [3:0]         move_pos,
  input  logic               new_game,
  input  logic               winner,
  output logic [1:0]         pos1,
  output logic [1:0]         pos2,
  output logic [1:0]         pos3,
  output logic [1:0]         pos4,
  output logic [1:0]         pos5,
  output logic [1:0]         pos6,
  output logic [1:0]         pos7,
  output logic [1:0]         pos8,
  output logic [1:0]         pos9,
  output logic               move_ready,
  output logic [1:0]         turn,
  output logic               move_ok,
  output logic               move_err,
  output logic               game_over,
  output logic [1:0]         result,
  output logic [3:0]         move_count,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic [SCORE_W-1:0] draws
);

  typedef enum logic [1:0] {
    StPlay,
    StCheck,
    StWin,
    StDraw
  } state_e;

  localparam logic [1:0]         Empty    = 2'b00;
  localparam logic [1:0]         Player1  = 2'b01;
  localparam logic [1:0]         Player2  = 2'b10;
  localparam logic [1:0]         ResDraw  = 2'b11;
  localparam logic [3:0]         FullMoves = 4'd9;
  localparam logic [SCORE_W-1:0] ScoreMax = '1;

  state_e             state_q, state_d;
  logic [1:0]         board_q [9];
  logic [1:0]         board_d [9];
  logic [1:0]         turn_q, turn_d;
  logic [1:0]         start_q, start_d;
  logic [3:0]         count_q, count_d;
  logic [1:0]         result_q, result_d;
  logic               ok_q, ok_d;
  logic               err_q, err_d;
  logic [SCORE_W-1:0] score1_q, score1_d;
  logic [SCORE_W-1:0] score2_q, score2_d;
  logic [SCORE_W-1:0] draws_q, draws_d;

  // Move target decode
  logic [8:0] cell_sel;
  logic       pos_legal;
  logic       target_free;
  logic [1:0] next_start;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == ScoreMax) ? v : v + 1'b1;
  endfunction

  function automatic logic [1:0] other(input logic [1:0] p);
    return (p == Player1) ? Player2 : Player1;
  endfunction

  // Decode the requested cell one-hot and check that it is on the board and empty.
  always_comb begin
    cell_sel    = '0;
    target_free = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cell_sel[i] = (move_pos == 4'(i + 1));
      if (cell_sel[i] && (board_q[i] != Empty)) begin
        target_free = 1'b0;
      end
    end
    pos_legal  = (move_pos != 4'd0) && (move_pos <= FullMoves);
    next_start = other(start_q);
  end

  // Next-state: new_game outranks everything but reset; CHECK consumes winner.
  always_comb begin
    state_d  = state_q;
    board_d  = board_q;
    turn_d   = turn_q;
    start_d  = start_q;
    count_d  = count_q;
    result_d = result_q;
    ok_d     = 1'b0;
    err_d    = 1'b0;
    score1_d = score1_q;
    score2_d = score2_q;
    draws_d  = draws_q;

    if (new_game) begin
      // Any pending CHECK verdict is discarded along with any same-cycle move.
      state_d  = StPlay;
      count_d  = '0;
      result_d = Empty;
      for (int i = 0; i < 9; i++) begin
        board_d[i] = Empty;
      end
      if (ALT_START) begin
        start_d = next_start;
        turn_d  = next_start;
      end else begin
        turn_d  = Player1;
      end
    end else begin
      unique case (state_q)
        StPlay: begin
          if (move_valid) begin
            if (pos_legal && target_free) begin
              for (int i = 0; i < 9; i++) begin
                if (cell_sel[i]) begin
                  board_d[i] = turn_q;
                end
              end
              count_d = count_q + 4'd1;
              ok_d    = 1'b1;
              state_d = StCheck;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        StCheck: begin
          // A win on the ninth move must take precedence over the draw test.
          if (winner) begin
            state_d  = StWin;
            result_d = turn_q;
            turn_d   = Empty;
            if (turn_q == Player1) begin
              score1_d = sat_inc(score1_q);
            end else begin
              score2_d = sat_inc(score2_q);
            end
          end else if (count_q == FullMoves) begin
            state_d  = StDraw;
            result_d = ResDraw;
            turn_d   = Empty;
            draws_d  = sat_inc(draws_q);
          end else begin
            state_d = StPlay;
            turn_d  = other(turn_q);
          end
        end
        StWin, StDraw: begin
          // Board and tallies frozen until new_game.
        end
        default: begin
          state_d = StPlay;
        end
      endcase
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StPlay;
      for (int i = 0; i < 9; i++) begin
        board_q[i] <= Empty;
      end
      turn_q   <= Player1;
      start_q  <= Player1;
      count_q  <= '0;
      result_q <= Empty;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      score1_q <= '0;
      score2_q <= '0;
      draws_q  <= '0;
    end else begin
      state_q  <= state_d;
      board_q  <= board_d;
      turn_q   <= turn_d;
      start_q  <= start_d;
      count_q  <= count_d;
      result_q <= result_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
      score1_q <= score1_d;
      score2_q <= score2_d;
      draws_q  <= draws_d;
    end
  end

  assign pos1 = board_q[0];
  assign pos2 = board_q[1];
  assign pos3 = board_q[2];
  assign pos4 = board_q[3];
  assign pos5 = board_q[4];
  assign pos6 = board_q[5];
  assign pos7 = board_q[6];
  assign pos8 = board_q[7];
  assign pos9 = board_q[8];

  assign move_ready = (state_q == StPlay);
  assign game_over  = (state_q == StWin) || (state_q == StDraw);
  assign turn       = turn_q;
  assign move_ok    = ok_q;
  assign move_err   = err_q;
  assign result     = result_q;
  assign move_count = count_q;
  assign score1     = score1_q;
  assign score2     = score2_q;
  assign draws      = draws_q;

endmodule

// File: doc/juego_control.md
Name: juego_control

Overview:
- Sequencing controller for one tic-tac-toe match; owns the 9-cell board register and the turn/score state.
- Accepts one move request at a time, rejects illegal moves and alternates players.
- Drives the board into the external 3-in-line win checker and consumes its `winner` result.
- Declares win or draw and keeps saturating match scores across games until reset.

Parameters:
- SCORE_W, 4, width of each saturating score counter.
- ALT_START, 0, 1 = starting player alternates on every new_game; 0 = player 1 always starts.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high; clears board, scores, FSM.
- move_valid  input  1  move request strobe (sampled only when move_ready=1).
- move_pos  input  4  target cell 1..9 (row-major, 1 = top-left).
- new_game  input  1  clear board and start next game; scores kept.
- winner  input  1  from win checker, combinational on pos1..pos9.
- pos1..pos9  output  2 each  cell state: 00 empty, 01 player 1, 10 player 2.
- move_ready  output  1  high in PLAY only.
- turn  output  2  player to move: 01 or 10; 00 when game over.
- move_ok  output  1  one-cycle pulse: move accepted.
- move_err  output  1  one-cycle pulse: move rejected.
- game_over  output  1  high in WIN or DRAW.
- result  output  2  00 none, 01 P1 won, 10 P2 won, 11 draw.
- move_count  output  4  moves placed this game, 0..9.
- score1, score2, draws  output  SCORE_W each  saturating match tallies.

Behaviour:
- Reset values:
  - all pos = 00, FSM = PLAY, turn = 01, move_count = 0, result = 00.
  - move_ok = move_err = game_over = 0, all scores = 0, start-player register = 01.
- States: PLAY, CHECK, WIN, DRAW.
- PLAY: move_ready = 1. On move_valid:
  - Accept if move_pos is in 1..9 and the target cell is 00. The cell is written with turn at the edge, move_ok pulses next cycle, move_count++, next state CHECK. turn is held until CHECK completes.
  - Reject if move_pos is 0 or 10..15, or the cell is non-zero. move_err pulses next cycle; board, turn and state are unchanged.
- CHECK: exactly one cycle; winner is sampled against the updated board.
  - winner=1 -> WIN, result = turn, the mover's score increments (saturating at all-ones), turn = 00.
  - else move_count=9 -> DRAW, result = 11, draws increments (saturating), turn = 00.
  - else -> PLAY, turn toggles 01<->10.
  - move_valid is ignored in this state (no err pulse).
- Win on the 9th move counts as WIN, not DRAW.
- Latency: request edge N -> board updated N+1, move_ok high during N+1. Outcome is visible (game_over/result/turn) after edge N+2; the next move is accepted no earlier than edge N+2.
- WIN/DRAW: game_over = 1, board frozen, move_valid ignored, move_ready = 0, scores stable.
- new_game (any state, except reset asserted):
  - Next cycle: board cleared, move_count = 0, result = 00, game_over = 0, state PLAY.
  - If ALT_START=1 the start register toggles and turn = new start value; otherwise turn = 01.
  - new_game has priority over a same-cycle move_valid (move dropped, no ok/err pulse).
  - new_game issued during CHECK aborts the pending result; scores are not updated.
- reset has priority over new_game and everything else; a reset mid-game discards the board and scores.
- move_ok and move_err are never high together and never high for two consecutive cycles from a single request.

Test Plan:
- Row win:
  - Stimulus: after reset, moves 1,4,2,5,3 with one request every 3 cycles.
  - Required: five move_ok pulses, pos1..3 = 01, pos4..5 = 10, result = 01, score1 = 1, game_over = 1, turn = 00.
- Illegal moves:
  - Stimulus: move 5, then move 5 again, then move_pos = 0, then move_pos = 12.
  - Required: three move_err pulses, turn stays 10, move_count = 1, board unchanged.
- Draw:
  - Stimulus: moves 1,2,3,5,4,6,8,7,9.
  - Required: result = 11, draws = 1, move_count = 9, no winner.
  - Then: 9th-move win sequence 1,2,3,5,4,6,8,9,7 -> result = 01, not a draw.
- Priority and gating:
  - Stimulus: new_game together with move_valid(pos 1).
  - Required: board all 00, no ok/err pulse.
  - Also: move_valid during CHECK and during WIN -> ignored.
- ALT_START=1:
  - Stimulus: three consecutive new_game.
  - Required: starting turn sequence 10, 01, 10; score saturation after 15 P1 wins (SCORE_W=4) -> score1 holds 15.
- Reset mid-game:
  - Stimulus: reset asserted after 3 moves.
  - Required: all pos = 00, turn = 01, scores = 0, move_ready = 1 on the following cycle.
